// File: rtl/clk_sched_pkg.sv
// Shared definitions for the clock tick scheduler: rate codes, channel state
// encoding and the rate-to-alignment-mask helper.
package clk_sched_pkg;

  localparam logic [1:0] RATE_DIV2  = 2'd0;
  localparam logic [1:0] RATE_DIV4  = 2'd1;
  localparam logic [1:0] RATE_DIV8  = 2'd2;
  localparam logic [1:0] RATE_DIV16 = 2'd3;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_SYNC = 2'd1,
    ST_RUN  = 2'd2
  } chan_state_e;

  // Low counter bits that must all be ones for a channel of this rate to tick.
  function automatic logic [3:0] rate_align_mask(input logic [1:0] rate);
    logic [3:0] mask;
    case (rate)
      RATE_DIV2: mask = 4'b0001;
      RATE_DIV4: mask = 4'b0011;
      RATE_DIV8: mask = 4'b0111;
      default:   mask = 4'b1111;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Pointer-based round-robin arbiter: combinational one-hot grant starting at
// rr_ptr, pointer moves to one past the granted requester.
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] ptr_next;
  logic [PTR_W-1:0] idx;
  logic             found;

  always_comb begin
    grant    = '0;
    found    = 1'b0;
    ptr_next = rr_ptr;
    idx      = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = PTR_W'((int'(rr_ptr) + i) % NREQ);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        ptr_next   = PTR_W'((int'(rr_ptr) + i + 1) % NREQ);
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      rr_ptr <= '0;
    end else begin
      rr_ptr <= ptr_next;
    end
  end

endmodule

// File: rtl/clock_tick_scheduler.sv
// Shared prescale counter producing per-requester clock-enable ticks at /2../16.
// Optional macro CLK_SCHED_PHASE_OUT_EN adds square-wave phase_clk outputs.
module clock_tick_scheduler
  import clk_sched_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int CNT_W = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [NREQ-1:0]   cmd_valid,
  input  logic [NREQ-1:0]   cmd_op,
  input  logic [2*NREQ-1:0] cmd_rate,
  output logic [NREQ-1:0]   cmd_ack,
  output logic [NREQ-1:0]   tick,
  output logic [NREQ-1:0]   active
`ifdef CLK_SCHED_PHASE_OUT_EN
  ,
  output logic [NREQ-1:0]   phase_clk
`endif
);

  // Handshake: a requester holds cmd_valid[k] until cmd_ack[k] pulses; the
  // command is applied on the edge that raises cmd_ack, and cmd_valid seen
  // during the ack cycle belongs to the old command, so it is masked here.
  logic [CNT_W-1:0] div_cnt;
  chan_state_e      state_q [NREQ];
  chan_state_e      state_d [NREQ];
  logic [1:0]       rate_q  [NREQ];
  logic [1:0]       rate_d  [NREQ];
  logic [NREQ-1:0]  grant;
  logic [NREQ-1:0]  align;
  logic [NREQ-1:0]  tick_d;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .Clock (Clock),
    .Reset (Reset),
    .req   (cmd_valid & ~cmd_ack),
    .grant (grant)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_comb begin
    align  = '0;
    tick_d = '0;
    for (int k = 0; k < NREQ; k++) begin
      state_d[k] = state_q[k];
      rate_d[k]  = rate_q[k];
    end
    for (int k = 0; k < NREQ; k++) begin
      align[k]  = (div_cnt[3:0] & rate_align_mask(rate_q[k])) == rate_align_mask(rate_q[k]);
      tick_d[k] = (state_q[k] != ST_OFF) && align[k];
      // An accepted command overrides the SYNC->RUN step on the same edge.
      if (grant[k]) begin
        if (cmd_op[k]) begin
          state_d[k] = ST_SYNC;
          rate_d[k]  = cmd_rate[2*k +: 2];
        end else begin
          state_d[k] = ST_OFF;
        end
      end else if (state_q[k] == ST_SYNC && align[k]) begin
        state_d[k] = ST_RUN;
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int k = 0; k < NREQ; k++) begin
        state_q[k] <= ST_OFF;
        rate_q[k]  <= RATE_DIV2;
      end
      cmd_ack <= '0;
      tick    <= '0;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        state_q[k] <= state_d[k];
        rate_q[k]  <= rate_d[k];
      end
      cmd_ack <= grant;
      tick    <= tick_d;
    end
  end

  always_comb begin
    active = '0;
    for (int k = 0; k < NREQ; k++) begin
      active[k] = (state_q[k] == ST_RUN);
    end
  end

`ifdef CLK_SCHED_PHASE_OUT_EN
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      phase_clk <= '0;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        if (state_d[k] == ST_OFF) begin
          phase_clk[k] <= 1'b0;
        end else if (tick_d[k]) begin
          phase_clk[k] <= ~phase_clk[k];
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_clock_tick_scheduler.sv
// Directed bench for clock_tick_scheduler; expected ticks derived from a
// cycle count kept since reset release.
module tb_clock_tick_scheduler;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic [3:0] cmd_valid = '0;
  logic [3:0] cmd_op = '0;
  logic [7:0] cmd_rate = '0;
  logic [3:0] cmd_ack;
  logic [3:0] tick;
  logic [3:0] active;
`ifdef CLK_SCHED_PHASE_OUT_EN
  logic [3:0] phase_clk;
`endif

  int errors = 0;
  int checks = 0;
  int cyc;
  logic [3:0] exp_q[$];

  clock_tick_scheduler #(.NREQ(4), .CNT_W(4)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .cmd_valid (cmd_valid),
    .cmd_op    (cmd_op),
    .cmd_rate  (cmd_rate),
    .cmd_ack   (cmd_ack),
    .tick      (tick),
    .active    (active)
`ifdef CLK_SCHED_PHASE_OUT_EN
    ,
    .phase_clk (phase_clk)
`endif
  );

  // Clock / reset: cyc equals the reference counter value at each negedge.
  always #5 Clock = ~Clock;

  always @(posedge Clock or negedge Reset) begin
    if (!Reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge Clock);
  endtask

  // Driver: hold one requester's command until its ack, bounded wait.
  task automatic send(input int k, input bit op, input logic [1:0] rate);
    bit got;
    got = 1'b0;
    cmd_op[k] = op;
    cmd_rate[2*k +: 2] = rate;
    cmd_valid[k] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (cmd_ack[k]) begin
        got = 1'b1;
        break;
      end
    end
    cmd_valid[k] = 1'b0;
    chk($sformatf("ack_ch%0d", k), got, 1);
  endtask

  initial begin
    bit first;
    bit seen;
    bit exp_t;
    logic [3:0] e;

    repeat (3) step();
    Reset = 1'b1;

    // Idle after reset
    for (int i = 0; i < 64; i++) begin
      step();
      chk("idle", {tick, active, cmd_ack}, 0);
    end

    // ch0 start at /4
    send(0, 1'b1, 2'd1);
    chk("ch0_active_before", active[0], 0);
    first = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (i == 0) chk("ch0_ack_pulse", cmd_ack[0], 0);
      if (tick[0]) begin
        first = 1'b1;
        break;
      end
    end
    chk("ch0_first_tick", first, 1);
    chk("ch0_tick_phase", cyc % 4, 0);
    chk("ch0_active_rise", active[0], 1);
    for (int i = 0; i < 12; i++) begin
      step();
      chk("ch0_period", tick[0], (cyc % 4) == 0);
    end

    // Stop on OFF channel 3; pointer returns to 0
    send(3, 1'b0, 2'd0);
    chk("ch3_off_stop", active[3], 0);

    // Burst from rr_ptr=0
    exp_q = {4'b0001, 4'b0010, 4'b0100, 4'b1000};
    cmd_op = 4'b0000;
    cmd_valid = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      step();
      e = exp_q.pop_front();
      chk("burst1_ack", cmd_ack, e);
      cmd_valid = cmd_valid & ~cmd_ack;
    end
    cmd_valid = 4'b0000;
    step();
    chk("burst1_done", cmd_ack, 0);
    chk("ch0_off_after_burst", active[0], 0);

    // Move pointer to 2, then burst again
    send(1, 1'b0, 2'd0);
    exp_q = {4'b0100, 4'b1000, 4'b0001, 4'b0010};
    cmd_valid = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      step();
      e = exp_q.pop_front();
      chk("burst2_ack", cmd_ack, e);
      cmd_valid = cmd_valid & ~cmd_ack;
    end
    cmd_valid = 4'b0000;

    // ch1 at /2, then retune to /16
    send(1, 1'b1, 2'd0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      exp_t = (cyc % 2) == 0;
      if (exp_t) seen = 1'b1;
      chk("ch1_div2_tick", tick[1], exp_t);
      chk("ch1_div2_active", active[1], seen);
    end
    send(1, 1'b1, 2'd3);
    chk("ch1_retune_active", active[1], 0);
    seen = 1'b0;
    for (int i = 0; i < 34; i++) begin
      step();
      exp_t = (cyc % 16) == 0;
      if (exp_t) seen = 1'b1;
      chk("ch1_div16_tick", tick[1], exp_t);
      chk("ch1_div16_active", active[1], seen);
    end

    // ch2 at /8, then stop
    send(2, 1'b1, 2'd2);
    for (int i = 0; i < 16; i++) begin
      step();
      chk("ch2_div8_tick", tick[2], (cyc % 8) == 0);
    end
    send(2, 1'b0, 2'd0);
    for (int i = 0; i < 100; i++) begin
      step();
      chk("ch2_stopped", {tick[2], active[2]}, 0);
      chk("ch1_background", tick[1], (cyc % 16) == 0);
    end
    send(0, 1'b0, 2'd0);
    chk("ch0_off_stop", active[0], 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("ch0_off_quiet", tick[0], 0);
    end

    // All channels running, then asynchronous reset
    send(0, 1'b1, 2'd0);
    send(2, 1'b1, 2'd2);
    send(3, 1'b1, 2'd1);
    repeat (20) step();
    chk("all_active", active, 4'hF);

`ifdef CLK_SCHED_PHASE_OUT_EN
    if ((cyc % 2) == 0) step();
    e[0] = phase_clk[0];
    for (int i = 0; i < 8; i++) begin
      step();
      if ((cyc % 2) == 0) chk("phase_toggle", phase_clk[0], ~e[0]);
      else                chk("phase_hold", phase_clk[0], e[0]);
      e[0] = phase_clk[0];
    end
    send(0, 1'b0, 2'd0);
    chk("phase_low_after_stop", phase_clk[0], 0);
    send(0, 1'b1, 2'd0);
    repeat (4) step();
`endif

    #2 Reset = 1'b0;
    #1 chk("reset_async", {tick, active, cmd_ack}, 0);
    step();
    step();
    Reset = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      chk("post_reset_idle", {tick, active, cmd_ack}, 0);
    end

    // Counter restarted at 0: /16 ticks land on cyc multiples of 16
    send(3, 1'b1, 2'd3);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("post_reset_div16", tick[3], (cyc % 16) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
